// File: rtl/spi_reg_sequencer_if.sv
// -----------------------------------------------------------------------------
// spi_reg_sequencer_if
// Bundles the SPI byte-engine handshake and the register-bank bus seen by
// spi_reg_sequencer.
//   master : the sequencer side. It drives byte_out, reg_addr, reg_wdata,
//            reg_we, reg_re, frame_active and err.
//   slave  : the environment side (byte engine, register bank, status
//            source). It drives ssel_active, byte_done, byte_in, reg_rdata
//            and status_in.
// -----------------------------------------------------------------------------
interface spi_reg_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 7
);

  // Byte engine side
  logic                  ssel_active;
  logic                  byte_done;
  logic [7:0]            byte_in;
  logic [7:0]            byte_out;

  // Register bank side
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;

  // Status / observation
  logic [6:0]            status_in;
  logic                  frame_active;
  logic                  err;

  modport master (
    input  ssel_active,
    input  byte_done,
    input  byte_in,
    input  reg_rdata,
    input  status_in,
    output byte_out,
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    output frame_active,
    output err
  );

  modport slave (
    output ssel_active,
    output byte_done,
    output byte_in,
    output reg_rdata,
    output status_in,
    input  byte_out,
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    input  frame_active,
    input  err
  );

endinterface

// File: rtl/spi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// spi_reg_sequencer
// Byte-level command sequencer behind the SPI slave byte engine. The first
// byte of each chip-select frame is a command: bit 7 selects read (1) or
// write (0), and the low ADDR_WIDTH bits give the start address. The
// following bytes are streamed into or out of the register bank, and the
// address auto-increments (wrapping modulo 2^ADDR_WIDTH). A status byte
// {err, status_in} is presented for shifting out during the command byte.
//
// Ports
//   clk    : system clock. All logic runs on the rising edge.
//   rst_n  : synchronous, active-low reset.
//   bus    : spi_reg_sequencer_if.master. It carries:
//              ssel_active, byte_done, byte_in, byte_out  (byte engine)
//              reg_addr, reg_wdata, reg_we, reg_re, reg_rdata  (register bank)
//              status_in, frame_active, err  (status)
//
// Parameters
//   ADDR_WIDTH : register address width (at most 7).
//   RO_BASE    : addresses at or above this value are read-only.
// -----------------------------------------------------------------------------
module spi_reg_sequencer #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter logic [6:0]  RO_BASE    = 7'h40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t                state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            byte_out_q, byte_out_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]            reg_wdata_q, reg_wdata_d;
  logic                  reg_we_q, reg_we_d;
  logic                  reg_re_q, reg_re_d;
  logic                  err_q, err_d;
  logic                  frame_active_q, frame_active_d;

  logic                  err_set, err_clr;
  logic                  byte_take;
  logic [7:0]            addr_ext;
  logic                  addr_ro;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  // The read-only check is done at 8 bits so that narrow address widths
  // compare correctly against the 7-bit RO_BASE.
  always_comb begin
    addr_ext                 = '0;
    addr_ext[ADDR_WIDTH-1:0] = addr_q;
  end

  assign addr_ro   = (addr_ext >= {1'b0, RO_BASE});
  assign addr_inc  = addr_q + ADDR_WIDTH'(1);
  assign cmd_addr  = bus.byte_in[ADDR_WIDTH-1:0];

  // A byte counts only while the frame is still selected. A byte_done that
  // arrives with the chip-select drop is discarded.
  assign byte_take = bus.ssel_active & bus.byte_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC: begin
        // After reset, wait for a clean frame boundary so that a frame that
        // was cut by the reset is not decoded halfway through.
        if (!bus.ssel_active) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.ssel_active) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (!bus.ssel_active) begin
          state_d = ST_IDLE;
        end else if (bus.byte_done) begin
          state_d = bus.byte_in[7] ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE, ST_READ: begin
        if (!bus.ssel_active) state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    byte_out_d  = byte_out_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        // Hold the reset values until the frame boundary.
      end

      ST_IDLE: begin
        // Track live status until the frame starts. byte_out then freezes,
        // so the value the slave has loaded is the one that is reported.
        if (!bus.ssel_active) byte_out_d = {err_q, bus.status_in};
      end

      ST_CMD: begin
        if (byte_take) begin
          addr_d  = cmd_addr;
          err_clr = 1'b1;
          if (bus.byte_in[7]) begin
            reg_re_d   = 1'b1;
            reg_addr_d = cmd_addr;
          end else begin
            byte_out_d = 8'h00;
          end
        end
      end

      ST_WRITE: begin
        byte_out_d = 8'h00;
        if (byte_take) begin
          if (addr_ro) begin
            err_set = 1'b1;
          end else begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = bus.byte_in;
          end
          addr_d = addr_inc;
        end
      end

      ST_READ: begin
        // The bank data belongs to the strobe issued on the previous edge.
        if (reg_re_q) byte_out_d = bus.reg_rdata;
        if (byte_take) begin
          addr_d     = addr_inc;
          reg_re_d   = 1'b1;
          reg_addr_d = addr_inc;
        end
      end

      default: begin
      end
    endcase

    // When set and clear happen in the same cycle, set wins.
    err_d          = err_set | (err_q & ~err_clr);
    frame_active_d = (state_d inside {ST_CMD, ST_WRITE, ST_READ});
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q         <= '0;
      byte_out_q     <= '0;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      reg_we_q       <= 1'b0;
      reg_re_q       <= 1'b0;
      err_q          <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      byte_out_q     <= byte_out_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_we_q       <= reg_we_d;
      reg_re_q       <= reg_re_d;
      err_q          <= err_d;
      frame_active_q <= frame_active_d;
    end
  end

  assign bus.byte_out     = byte_out_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_wdata    = reg_wdata_q;
  assign bus.reg_we       = reg_we_q;
  assign bus.reg_re       = reg_re_q;
  assign bus.err          = err_q;
  assign bus.frame_active = frame_active_q;

endmodule
